pass_responder: RTL

PASS_RESPONDER -- requirements
Module: pass_responder

---
 rtl/pass_pkg.sv | 51 +++++
 rtl/pass_responder_if.sv | 29 ++
 rtl/pass_edge_det.sv | 32 +++
 rtl/pass_responder.sv | 121 ++++++++++++
 4 files changed

// File: rtl/pass_pkg.sv
// Shared definitions for the pass sequencer and the pass responder.
// Holds the phase and state encodings and the pass-length width.
package pass_pkg;

  localparam int unsigned LEN_W  = 8;
  localparam int unsigned N_PASS = 3;

  typedef enum logic [1:0] {
    PH_NONE = 2'b00,
    PH_F0   = 2'b01,
    PH_F1   = 2'b10,
    PH_B    = 2'b11
  } phase_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN_F0 = 3'd1,
    ST_RUN_F1 = 3'd2,
    ST_RUN_B  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Pass vectors are ordered {b, f1, f0}.
  function automatic logic [N_PASS-1:0] phase_mask(phase_e p);
    case (p)
      PH_F0:   return 3'b001;
      PH_F1:   return 3'b010;
      PH_B:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic phase_e onehot_phase(logic [N_PASS-1:0] v);
    case (v)
      3'b001:  return PH_F0;
      3'b010:  return PH_F1;
      3'b100:  return PH_B;
      default: return PH_NONE;
    endcase
  endfunction

  function automatic state_e run_state(phase_e p);
    case (p)
      PH_F0:   return ST_RUN_F0;
      PH_F1:   return ST_RUN_F1;
      PH_B:    return ST_RUN_B;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/pass_responder_if.sv
// Handshake between the pass sequencer (master) and the pass responder (slave).
interface pass_responder_if;
  import pass_pkg::*;

  logic             en_i;
  logic             f0_pass_i;
  logic             f1_pass_i;
  logic             b_pass_i;
  logic [LEN_W-1:0] len_i;
  logic             step_o;
  logic [LEN_W-1:0] addr_o;
  logic [1:0]       phase_o;
  logic             busy_o;
  logic             f0_end_o;
  logic             f1_end_o;
  logic             b_end_o;
  logic             err_o;

  modport master (
    output en_i, f0_pass_i, f1_pass_i, b_pass_i, len_i,
    input  step_o, addr_o, phase_o, busy_o, f0_end_o, f1_end_o, b_end_o, err_o
  );

  modport slave (
    input  en_i, f0_pass_i, f1_pass_i, b_pass_i, len_i,
    output step_o, addr_o, phase_o, busy_o, f0_end_o, f1_end_o, b_end_o, err_o
  );

endinterface

// File: rtl/pass_edge_det.sv
// Registers the pass request levels and flags their rising edges.
// A level already high out of reset is not an edge until it has been seen low.
module pass_edge_det #(
  parameter int unsigned N = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] pass_i,
  output logic [N-1:0] lvl_o,
  output logic [N-1:0] rise_c
);

  logic [N-1:0] lvl_q;
  logic [N-1:0] prv_q;
  logic [N-1:0] arm_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lvl_q <= '0;
      prv_q <= '0;
      arm_q <= '0;
    end else begin
      lvl_q <= pass_i;
      prv_q <= lvl_q;
      arm_q <= arm_q | ~pass_i;
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_c = lvl_q & ~prv_q & arm_q;

endmodule

// File: rtl/pass_responder.sv
// Executes one forward/backward stepping pass per sequencer request and
// reports completion or protocol errors back to the sequencer.
module pass_responder
  import pass_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  pass_responder_if.slave bus
);

  logic [N_PASS-1:0] pass_raw;
  logic [N_PASS-1:0] lvl;
  logic [N_PASS-1:0] rise;

  assign pass_raw = {bus.b_pass_i, bus.f1_pass_i, bus.f0_pass_i};

  pass_edge_det #(.N(N_PASS)) u_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .pass_i (pass_raw),
    .lvl_o  (lvl),
    .rise_c (rise)
  );

  state_e            state_q;
  phase_e            phase_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              busy_q;
  logic              err_q;
  logic [N_PASS-1:0] end_q;

  logic              run_c;
  logic              act_c;
  logic              step_c;
  logic              last_c;
  logic [LEN_W-1:0]  addr_c;

  // Step strobe follows en_i in the same cycle so a paused cycle never steps.
  always_comb begin
    run_c  = (state_q == ST_RUN_F0) || (state_q == ST_RUN_F1) || (state_q == ST_RUN_B);
    act_c  = |(lvl & phase_mask(phase_q));
    step_c = run_c && bus.en_i && act_c && (len_q != '0);
    last_c = (cnt_q == (len_q - LEN_W'(1)));
    addr_c = '0;
    if (step_c) begin
      addr_c = (phase_q == PH_B) ? (len_q - LEN_W'(1) - cnt_q) : cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      phase_q <= PH_NONE;
      len_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      end_q   <= '0;
    end else begin
      err_q <= 1'b0;
      end_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|rise) begin
            if ($countones(lvl) > 1) begin
              err_q <= 1'b1;
            end else begin
              state_q <= run_state(onehot_phase(lvl));
              phase_q <= onehot_phase(lvl);
              len_q   <= bus.len_i;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_RUN_F0, ST_RUN_F1, ST_RUN_B: begin
          if (!act_c) begin
            // Sequencer withdrew the request mid-pass: abandon without an end pulse.
            state_q <= ST_IDLE;
            phase_q <= PH_NONE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b1;
          end else if (len_q == '0) begin
            state_q <= ST_DONE;
            end_q   <= phase_mask(phase_q);
          end else if (step_c) begin
            if (last_c) begin
              state_q <= ST_DONE;
              end_q   <= phase_mask(phase_q);
            end else begin
              cnt_q <= cnt_q + LEN_W'(1);
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          phase_q <= PH_NONE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          phase_q <= PH_NONE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.step_o   = step_c;
  assign bus.addr_o   = addr_c;
  assign bus.phase_o  = phase_q;
  assign bus.busy_o   = busy_q;
  assign bus.f0_end_o = end_q[0];
  assign bus.f1_end_o = end_q[1];
  assign bus.b_end_o  = end_q[2];
  assign bus.err_o    = err_q;

endmodule
